// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, one multiplier bit per clock.
// Signed or unsigned operands; product is held until the next completion.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   x,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q;
  logic [2*WIDTH:0]     acc_q;
  logic [2*WIDTH:0]     acc_d;
  logic [WIDTH:0]       a_q;
  logic                 sm_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic                 last;
  logic [WIDTH+1:0]     hi_ext;
  logic [WIDTH+1:0]     a_ext;
  logic [WIDTH+1:0]     sum;

  // One guard bit above the WIDTH+1 partial sum keeps the bit shifted
  // back in exact for both modes (sign in signed, carry in unsigned).
  always_comb begin
    last   = (cnt_q == CNT_W'(WIDTH));
    hi_ext = {sm_q & acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH]};
    a_ext  = {sm_q & a_q[WIDTH], a_q};
    sum    = hi_ext;
    if (acc_q[0]) begin
      if (last && sm_q) sum = hi_ext - a_ext;
      else              sum = hi_ext + a_ext;
    end
    acc_d  = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      sm_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= signed_mode ? {a[WIDTH-1], a}
                                   : {1'b0, a};
            sm_q    <= signed_mode;
            acc_q   <= {{(WIDTH+1){1'b0}}, x};
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last) begin
            prod_q  <= acc_d[2*WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: vector table, corner sequences and random ops
// for WIDTH=32, plus an exhaustive sweep of a WIDTH=4 instance.
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, sm;
  logic [31:0] a, x;
  logic        busy, done;
  logic [63:0] prod;

  logic        start4, sm4;
  logic [3:0]  a4, x4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int nchk = 0;
  int nerr = 0;

  seq_mult_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
    .a(a), .x(x), .busy(busy), .done(done), .product(prod)
  );

  seq_mult_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .x(x4), .busy(busy4), .done(done4), .product(prod4)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] x;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] ref32(input logic s,
                                        input logic [31:0] aa,
                                        input logic [31:0] xx);
    longint p;
    logic [63:0] u;
    if (s) begin
      p = longint'($signed(aa)) * longint'($signed(xx));
      return p;
    end
    u = {32'b0, aa} * {32'b0, xx};
    return u;
  endfunction

  function automatic logic [7:0] ref4(input logic s,
                                      input logic [3:0] aa,
                                      input logic [3:0] xx);
    int p;
    if (s) p = int'($signed(aa)) * int'($signed(xx));
    else   p = int'({28'b0, aa}) * int'({28'b0, xx});
    return p[7:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run32(input logic s, input logic [31:0] aa,
                       input logic [31:0] xx,
                       output logic [63:0] p, output int n);
    start = 1'b1; sm = s; a = aa; x = xx;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", {63'b0, busy}, 64'd1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_off_at_done", {63'b0, busy}, 64'd0);
    p = prod;
  endtask

  task automatic run4(input logic s, input logic [3:0] aa,
                      input logic [3:0] xx,
                      output logic [7:0] p, output int n);
    start4 = 1'b1; sm4 = s; a4 = aa; x4 = xx;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    p = prod4;
  endtask

  vec_t        tv[9];
  logic [63:0] p, p2, want;
  logic [7:0]  q;
  logic [31:0] ra, rx;
  logic        rs;
  int          n, n2, nb, nd;

  initial begin
    tv[0] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1};
    tv[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tv[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    tv[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tv[4] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000};
    tv[5] = '{1'b0, 32'h00000000, 32'h12345678, 64'h0};
    tv[6] = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tv[7] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
    tv[8] = '{1'b0, 32'h7FFFFFFF, 32'h00000002, 64'h00000000_FFFFFFFE};

    start = 0; sm = 0; a = 0; x = 0;
    start4 = 0; sm4 = 0; a4 = 0; x4 = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_prod4", {56'b0, prod4}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run32(tv[i].s, tv[i].a, tv[i].x, p, n);
      chk($sformatf("vec%0d_prod", i), p, tv[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(n), 64'd32);
      @(negedge clk);
      chk("done_one_cycle", {63'b0, done}, 64'd0);
      chk("prod_hold", prod, tv[i].exp);
    end

    // start pulsed mid-run with other operands must be ignored
    start = 1'b1; sm = 1'b1; a = 32'hFFFFFFFD; x = 32'd5;
    @(negedge clk);
    nb = 0; nd = 0; p = '0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) begin nd++; p = prod; end
      start = (i == 8);
      a = $urandom; x = $urandom; sm = i[0];
      @(negedge clk);
    end
    chk("ign_prod", p, 64'hFFFFFFFF_FFFFFFF1);
    chk("ign_busy_cycles", 64'(nb), 64'd32);
    chk("ign_done_pulses", 64'(nd), 64'd1);

    // second start asserted on the done cycle
    run32(1'b1, 32'd7, 32'hFFFFFFF7, p, n);
    run32(1'b0, 32'hDEADBEEF, 32'h10, p2, n2);
    chk("b2b_first", p, 64'hFFFFFFFF_FFFFFFC1);
    chk("b2b_second", p2, 64'h0000000D_EADBEEF0);
    chk("b2b_lat", 64'(n2), 64'd32);
    @(negedge clk);
    chk("b2b_done_low", {63'b0, done}, 64'd0);

    // reset in the middle of an operation
    start = 1'b1; sm = 1'b0; a = 32'h1234; x = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_prod_hold", prod, 64'h0000000D_EADBEEF0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_prod", prod, 64'd0);
    @(negedge clk);
    run32(1'b1, 32'hFFFF0000, 32'h00012345, p, n);
    chk("post_rst_prod", p, ref32(1'b1, 32'hFFFF0000, 32'h00012345));
    chk("post_rst_lat", 64'(n), 64'd32);

    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom);
      ra = $urandom; rx = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[0], 31'b0};
      if ($urandom_range(0, 3) == 0) rx = {32{rx[0]}};
      want = ref32(rs, ra, rx);
      run32(rs, ra, rx, p, n);
      chk($sformatf("rnd%0d_s%0d_%h_%h", i, rs, ra, rx), p, want);
      chk("rnd_lat", 64'(n), 64'd32);
    end

    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int xi = 0; xi < 16; xi++) begin
          run4(1'(s), 4'(ai), 4'(xi), q, n);
          chk($sformatf("w4_s%0d_%0d_%0d", s, ai, xi),
              {56'b0, q}, {56'b0, ref4(1'(s), 4'(ai), 4'(xi))});
          chk("w4_lat", 64'(n), 64'd4);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
